// File: rtl/pipe_pkg.sv
// Shared fetch-stage definitions: reset PC, bubble instruction and fetch FSM states.
package pipe_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // StReq: request at pc; StHold: skid full, request off; StDrain: discard in-flight response.
  typedef enum logic [1:0] {
    StReq,
    StHold,
    StDrain
  } fetch_state_e;

  // Instruction addresses are always word aligned; the two low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its pc+4 while IF/ID is stalled.
module fetch_skid_buf
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  input  logic [31:0] i_pc_plus_4,
  output logic [31:0] o_data,
  output logic [31:0] o_pc_plus_4,
  output logic        o_valid
);

  logic [31:0] r_data;
  logic [31:0] r_pc_plus_4;
  logic        r_valid;

  // Clear beats load beats drain; payload only changes on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data      <= NOP_INSTR;
      r_pc_plus_4 <= '0;
      r_valid     <= 1'b0;
    end else if (i_clear) begin
      r_valid     <= 1'b0;
    end else if (i_load) begin
      r_data      <= i_data;
      r_pc_plus_4 <= i_pc_plus_4;
      r_valid     <= 1'b1;
    end else if (i_drain) begin
      r_valid     <= 1'b0;
    end
  end

  assign o_data      = r_data;
  assign o_pc_plus_4 = r_pc_plus_4;
  assign o_valid     = r_valid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, stall skid, redirect with drain.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            o_pc_plus_4,
  output logic [31:0]            o_Instruction,
  output logic                   o_valid,
  output logic                   o_flush
);

  pipe_pkg::fetch_state_e r_state;

  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic        r_req;
  logic [31:0] r_pc_plus_4;
  logic [31:0] r_instr;
  logic        r_valid;

  logic        w_ack;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic        w_skid_load;
  logic        w_skid_drain;
  logic        w_skid_clear;
  logic [31:0] w_skid_data;
  logic [31:0] w_skid_pc_plus_4;
  logic        w_skid_valid;

  // An ack only counts against a request we actually issued.
  assign w_ack    = imem.imem_ack & r_req;
  assign w_target = pipe_pkg::word_align(redirect_pc);
  assign w_pc_inc = r_pc + 32'd4;

  assign w_skid_load  = (r_state == pipe_pkg::StReq) && w_ack && if_stall && !redirect;
  assign w_skid_drain = (r_state == pipe_pkg::StHold) && !if_stall && !redirect;
  assign w_skid_clear = redirect;

  fetch_skid_buf u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_skid_load),
    .i_drain     (w_skid_drain),
    .i_clear     (w_skid_clear),
    .i_data      (imem.imem_rdata),
    .i_pc_plus_4 (w_pc_inc),
    .o_data      (w_skid_data),
    .o_pc_plus_4 (w_skid_pc_plus_4),
    .o_valid     (w_skid_valid)
  );

  // Fetch FSM with registered request, address and IF/ID-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= pipe_pkg::StReq;
      r_pc        <= RESET_PC;
      r_addr      <= RESET_PC;
      r_req       <= 1'b0;
      r_pc_plus_4 <= RESET_PC;
      r_instr     <= pipe_pkg::NOP_INSTR;
      r_valid     <= 1'b0;
    end else begin
      unique case (r_state)
        pipe_pkg::StReq: begin
          if (redirect) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
            if (r_req && !imem.imem_ack) begin
              // Keep the old request on the bus until its ack, then throw the data away.
              r_state <= pipe_pkg::StDrain;
            end else begin
              r_addr <= w_target;
              r_req  <= 1'b1;
            end
          end else if (w_ack) begin
            r_pc <= w_pc_inc;
            if (if_stall) begin
              r_req   <= 1'b0;
              r_state <= pipe_pkg::StHold;
            end else begin
              r_pc_plus_4 <= w_pc_inc;
              r_instr     <= imem.imem_rdata;
              r_valid     <= 1'b1;
              r_addr      <= w_pc_inc;
              r_req       <= 1'b1;
            end
          end else begin
            // Also raises the very first request after reset release.
            r_req <= 1'b1;
            if (!if_stall) begin
              r_valid <= 1'b0;
            end
          end
        end
        pipe_pkg::StHold: begin
          if (redirect) begin
            r_pc    <= w_target;
            r_addr  <= w_target;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
            r_state <= pipe_pkg::StReq;
          end else if (!if_stall) begin
            r_pc_plus_4 <= w_skid_pc_plus_4;
            r_instr     <= w_skid_data;
            r_valid     <= w_skid_valid;
            r_addr      <= r_pc;
            r_req       <= 1'b1;
            r_state     <= pipe_pkg::StReq;
          end
        end
        pipe_pkg::StDrain: begin
          if (redirect) begin
            r_pc    <= w_target;
            r_valid <= 1'b0;
          end
          if (imem.imem_ack) begin
            r_addr  <= redirect ? w_target : r_pc;
            r_req   <= 1'b1;
            r_state <= pipe_pkg::StReq;
          end
        end
        default: r_state <= pipe_pkg::StReq;
      endcase
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign o_pc_plus_4    = r_pc_plus_4;
  assign o_Instruction  = r_instr;
  assign o_valid        = r_valid;
  assign o_flush        = redirect;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model, expected-stream scoreboard, monitor.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] o_pc_plus_4;
  logic [31:0] o_Instruction;
  logic        o_valid;
  logic        o_flush;

  if_fetch_unit_if u_bus ();

  if_fetch_unit #(
    .RESET_PC (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_stall      (if_stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem          (u_bus),
    .o_pc_plus_4   (o_pc_plus_4),
    .o_Instruction (o_Instruction),
    .o_valid       (o_valid),
    .o_flush       (o_flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: every word holds its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a;
  endfunction

  // Reference model: the pipeline must see consecutive words from the last redirect/reset
  // target, each exactly once, in order.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_t;

  fetch_t      exp_q[$];
  logic [31:0] next_push = '0;
  fetch_t      mon_e;
  int          n_consumed = 0;

  task automatic sb_fill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc4: next_push + 32'd4, instr: mem_word(next_push)});
      next_push = next_push + 32'd4;
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    exp_q.delete();
    next_push = start & ~32'h0000_0003;
    sb_fill();
  endtask

  // Memory model: latency per request, protocol check while a request is outstanding.
  int          lat_mode = 0;  // negative selects random latency 0..2
  bit          pend = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          req_starts = 0;
  logic [31:0] last_start = '0;

  initial begin
    u_bus.imem_ack   = 1'b0;
    u_bus.imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pend           = 1'b0;
        u_bus.imem_ack = 1'b0;
      end else begin
        if (u_bus.imem_ack) pend = 1'b0;
        if (pend) begin
          check_bit("req_held", u_bus.imem_req, 1'b1);
          check("addr_held", u_bus.imem_addr, pend_addr);
        end else if (u_bus.imem_req) begin
          pend       = 1'b1;
          pend_addr  = u_bus.imem_addr;
          wait_cnt   = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
          req_starts++;
          last_start = pend_addr;
        end
        if (pend && wait_cnt == 0) begin
          u_bus.imem_ack   = 1'b1;
          u_bus.imem_rdata = mem_word(pend_addr);
        end else begin
          u_bus.imem_ack   = 1'b0;
          u_bus.imem_rdata = 32'hDEAD_BEEF;
          if (pend) wait_cnt--;
        end
      end
    end
  end

  // Monitor: the IF/ID register takes the outputs at every edge with no stall and no flush.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !redirect && o_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: got word %08h, expected none queued", o_Instruction);
        end else if (!if_stall) begin
          mon_e = exp_q.pop_front();
          check("consume_pc4", o_pc_plus_4, mon_e.pc4);
          check("consume_instr", o_Instruction, mon_e.instr);
          n_consumed++;
        end else begin
          check("stall_pc4", o_pc_plus_4, exp_q[0].pc4);
          check("stall_instr", o_Instruction, exp_q[0].instr);
        end
      end
    end
  end

  // One stimulus cycle: redirect is a one-cycle pulse, scoreboard kept topped up.
  task automatic cycle();
    @(posedge clk);
    #2;
    redirect = 1'b0;
    sb_fill();
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    sb_restart(target);
  endtask

  task automatic wait_new_req(input string name, output logic [31:0] addr);
    int start;
    bit seen;
    start = req_starts;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (req_starts != start) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no new request, expected one within 20 cycles", name);
    end
    addr = last_start;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      if (o_valid) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got o_valid=0, expected 1 within 20 cycles", name);
    end
  endtask

  logic [31:0] a;
  logic [31:0] tgt;

  initial begin
    // Reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    check_bit("rst_imem_req", u_bus.imem_req, 1'b0);
    check("rst_pc_plus_4", o_pc_plus_4, RST_PC);
    check("rst_instr", o_Instruction, 32'h0);
    check_bit("rst_valid", o_valid, 1'b0);
    check_bit("rst_flush", o_flush, 1'b0);
    sb_restart(RST_PC);
    repeat (2) cycle();
    rst = 1'b0;
    #1 check_bit("req_low_at_release", u_bus.imem_req, 1'b0);

    // Zero-latency streaming from reset.
    wait_new_req("first_fetch", a);
    check("first_fetch_addr", a, RST_PC);
    cycle();
    check("first_pc4", o_pc_plus_4, 32'h0000_3004);
    check("first_instr", o_Instruction, 32'h0000_3000);
    check_bit("first_valid", o_valid, 1'b1);
    cycle();
    check("second_pc4", o_pc_plus_4, 32'h0000_3008);
    check("second_instr", o_Instruction, 32'h0000_3004);
    repeat (3) begin
      cycle();
      check_bit("stream_no_gap", o_valid, 1'b1);
    end

    // Three-cycle stall: one word skidded, request off while holding.
    if_stall = 1'b1;
    cycle();
    check_bit("hold_req_off", u_bus.imem_req, 1'b0);
    cycle();
    check_bit("hold_req_off", u_bus.imem_req, 1'b0);
    cycle();
    if_stall = 1'b0;
    repeat (6) cycle();

    // Redirect one cycle after a 3-cycle-latency request: drain, then refetch at target.
    lat_mode = 3;
    wait_new_req("slow_req", a);
    cycle();
    do_redirect(32'h0000_4000);
    #1 check_bit("flush_pulse", o_flush, 1'b1);
    cycle();
    check_bit("flush_one_cycle", o_flush, 1'b0);
    wait_new_req("redir_req", a);
    check("redir_addr", a, 32'h0000_4000);
    wait_valid("redir_word");
    check("redir_pc4", o_pc_plus_4, 32'h0000_4004);

    // Redirect and stall together: redirect wins.
    lat_mode = 1;
    cycle();
    if_stall = 1'b1;
    do_redirect(32'h0000_6002);
    #1 check_bit("stall_redir_flush", o_flush, 1'b1);
    cycle();
    check_bit("stall_redir_valid", o_valid, 1'b0);
    if_stall = 1'b0;
    wait_new_req("stall_redir_req", a);
    check("stall_redir_addr", a, 32'h0000_6000);

    // Top-of-memory target wraps to address 0.
    lat_mode = 0;
    repeat (4) cycle();
    do_redirect(32'hFFFF_FFFF);
    wait_new_req("wrap_req", a);
    check("wrap_addr", a, 32'hFFFF_FFFC);
    cycle();
    check("wrap_pc4", o_pc_plus_4, 32'h0000_0000);
    check("wrap_instr", o_Instruction, 32'hFFFF_FFFC);
    check("wrap_next_addr", u_bus.imem_addr, 32'h0000_0000);
    repeat (3) cycle();

    // Asynchronous reset while draining.
    lat_mode = 3;
    wait_new_req("pre_drain_req", a);
    cycle();
    do_redirect(32'h0000_5000);
    cycle();
    #1 rst = 1'b1;
    sb_restart(RST_PC);
    #1;
    check_bit("drain_rst_req", u_bus.imem_req, 1'b0);
    check_bit("drain_rst_valid", o_valid, 1'b0);
    check("drain_rst_pc4", o_pc_plus_4, RST_PC);
    check("drain_rst_instr", o_Instruction, 32'h0);
    repeat (2) cycle();
    rst = 1'b0;
    wait_new_req("post_rst_req", a);
    check("post_rst_addr", a, RST_PC);

    // Randomized traffic: latency, stalls and redirects.
    lat_mode = -1;
    for (int i = 0; i < 600; i++) begin
      cycle();
      if_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) begin
        tgt = $urandom;
        do_redirect(tgt);
      end
    end
    if_stall = 1'b0;
    repeat (20) cycle();
    check_bit("enough_words_consumed", n_consumed >= 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, PC value loaded on reset.
REQ-002 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port rst  in  1  reset, asynchronous and active-high.
REQ-004 Port if_stall  in  1  load-use hold from the hazard unit; freezes the IF/ID-facing outputs.
REQ-005 Port redirect  in  1  branch/jump taken; single-cycle pulse.
REQ-006 Port redirect_pc  in  32  target of redirect; bits [1:0] are ignored and forced to 0.
REQ-007 Port imem_req  out  1  instruction-memory request.
REQ-008 Port imem_addr  out  32  word-aligned fetch address.
REQ-009 Port imem_ack  in  1  single-cycle response strobe; imem_rdata is valid in that cycle.
REQ-010 Port imem_rdata  in  32  fetched instruction.
REQ-011 Port o_pc_plus_4  out  32  fetch address + 4, to IF/ID i_pc_plus_4.
REQ-012 Port o_Instruction  out  32  fetched word, to IF/ID i_Instruction.
REQ-013 Port o_valid  out  1  o_Instruction holds a real fetched word.
REQ-014 Port o_flush  out  1  IF/ID flush request, driven to IF/ID rst.

Function
REQ-015 The block SHALL allow at most one outstanding imem request; imem_req and imem_addr SHALL be held stable from assertion until imem_ack.
REQ-016 FSM states SHALL be REQ (request pc), HOLD (skid full, request off) and DRAIN (in-flight response to be discarded).
REQ-017 REQ, ack, no stall, no redirect: outputs load {pc+4, imem_rdata}, o_valid<=1, pc<=pc+4, stay in REQ.
REQ-018 REQ, ack, if_stall=1: outputs hold, the word and pc+4 go into the skid buffer, pc<=pc+4, next state HOLD, imem_req=0 in HOLD.
REQ-019 HOLD, if_stall=0: outputs load from the skid buffer, next state REQ.
REQ-020 REQ, no ack, if_stall=0: o_valid<=0, outputs otherwise hold.
REQ-021 Under if_stall=1 in any state, o_pc_plus_4, o_Instruction and o_valid SHALL be unchanged.
REQ-022 Redirect SHALL have priority over stall and ack: pc<=redirect_pc, skid is invalidated, o_valid<=0.
REQ-023 o_flush SHALL be combinationally equal to redirect.
REQ-024 Redirect in REQ with a request pending and no ack: next state DRAIN; the old address is kept on imem_req/imem_addr until ack, and that ack's data is discarded; next state REQ with the new pc.
REQ-025 Redirect coinciding with ack: the data is discarded, next state REQ at redirect_pc.
REQ-026 Redirect in DRAIN SHALL update pc only; the state remains DRAIN.
REQ-027 Redirect in HOLD SHALL discard the skid, next state REQ.
REQ-028 PC arithmetic SHALL be modulo 2^32: pc 32'hFFFF_FFFC gives o_pc_plus_4 = 0 and next fetch address 0.
REQ-029 imem_addr SHALL equal pc in REQ and the latched in-flight address in DRAIN.

Reset
REQ-030 While rst=1: pc=RESET_PC, state REQ, imem_req=0, o_pc_plus_4=RESET_PC, o_Instruction=0, o_valid=0, skid empty; this SHALL take effect immediately without a clock.
REQ-031 Reset asserted mid-request SHALL abandon that request; imem_req SHALL first reassert on the first rising edge after rst deasserts.

Structure
REQ-032 Shared package pipe_pkg SHALL hold RESET_PC, NOP_INSTR (32'h0) and the fetch FSM state enum.
REQ-033 The one-entry skid buffer (data, pc+4, valid; load, drain and clear controls) SHALL be the sub-module fetch_skid_buf.

Verification
REQ-034 Reset release, memory acks every request in the same cycle with rdata=addr -> o_valid=1, o_pc_plus_4=0x3004, o_Instruction=0x3000; then 0x3008/0x3004, with no gaps.
REQ-035 if_stall high 3 cycles during streaming -> outputs frozen, one word skidded, imem_req=0 in HOLD; after release the sequence continues with no loss and no duplicate.
REQ-036 Ack latency 3 cycles, redirect to 0x4000 one cycle after req -> o_flush high 1 cycle, old imem_addr held until ack and its data dropped, next imem_addr=0x4000, next o_pc_plus_4=0x4004.
REQ-037 redirect and if_stall high in the same cycle -> redirect wins: o_valid=0, pc=target, o_flush=1.
REQ-038 redirect_pc=0xFFFF_FFFF -> imem_addr=0xFFFF_FFFC, o_pc_plus_4=0x0000_0000, following fetch address 0x0000_0000.
REQ-039 rst asserted between clock edges while in DRAIN -> all outputs take reset values immediately, imem_req=0, and the next fetch after release is 0x3000.
